// File: rtl/hazard_fwd_unit_pkg.sv
// hazard_fwd_unit_pkg
//   Shared definitions for the hazard / forwarding unit:
//   - forward select codes for the EX operand 3:1 mux
//   - FSM state type (RUN / MD_BUSY)
//   - pipeline slot record tracked for EX, MEM and WB
//   - BUSY_W: width of the mul/div busy counter (latency range 2..15)
//   - writes_reg(): true when a slot will write a non-zero register equal to r
package hazard_fwd_unit_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam int unsigned BUSY_W = 4;

  typedef enum logic {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } state_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       regwrite;
    logic       memread;
  } slot_t;

  function automatic logic writes_reg(input slot_t s, input logic [4:0] r);
    return s.valid && s.regwrite && (s.rd != 5'd0) && (s.rd == r);
  endfunction

endpackage

// File: rtl/hazard_fwd_unit_fwd_sel.sv
// fwd_sel_unit
//   Computes one EX operand forward select from a single source register
//   and the MEM / WB slots. MEM (younger result) wins over WB.
//   Ports:
//     src       in  5   EX source register
//     mem_slot  in      MEM slot record
//     wb_slot   in      WB slot record
//     sel       out 2   FWD_RF / FWD_WB / FWD_MEM (never 2'b11)
module fwd_sel_unit
  import hazard_fwd_unit_pkg::*;
(
  input  logic [4:0] src,
  input  slot_t      mem_slot,
  input  slot_t      wb_slot,
  output logic [1:0] sel
);

  // Source fields and memread of the later slots play no part in forwarding.
  logic unused_ok;
  assign unused_ok = ^{mem_slot.rs, mem_slot.rt, mem_slot.memread,
                       wb_slot.rs, wb_slot.rt, wb_slot.memread};

  always_comb begin
    sel = FWD_RF;
    if (writes_reg(mem_slot, src)) begin
      sel = FWD_MEM;
    end else if (writes_reg(wb_slot, src)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit
//   Hazard detection and forwarding control for a 5-stage pipeline.
//   Tracks EX/MEM/WB slots, drives EX operand forward selects, stalls on
//   load-use and (optionally) on a mul/div issued while the unit is busy.
//   Configuration macro: HAZARD_MULDIV_EN enables the RUN/MD_BUSY FSM and
//   the mul/div busy counter; when undefined id_muldiv is ignored.
//   Parameters: MULDIV_LAT (2..15) mul/div occupancy, CNT_W stall counter width.
//   Ports:
//     clk, rst (async, active-low)
//     id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_rd,
//     id_regwrite, id_memread, id_muldiv   decode-slot description
//     flush                                 taken branch, kills decode slot
//     fwd_a_sel, fwd_b_sel                  EX operand mux selects
//     pc_write, ifid_write, idex_bubble     pipeline enables / bubble
//     stall_count                           saturating stall-cycle count
module hazard_fwd_unit
  import hazard_fwd_unit_pkg::*;
#(
  parameter int unsigned MULDIV_LAT = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [4:0]       id_rd,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             id_muldiv,
  input  logic             flush,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_bubble,
  output logic [CNT_W-1:0] stall_count
);

  slot_t ex_q, mem_q, wb_q, ex_d;
  logic  load_use, md_stall, stall, ex_load;

  always_comb begin
    load_use = ex_q.valid && ex_q.memread && ex_q.regwrite && (ex_q.rd != 5'd0) &&
               id_valid &&
               ((id_use_rs && (id_rs == ex_q.rd)) || (id_use_rt && (id_rt == ex_q.rd)));
  end

  assign stall = load_use || md_stall;

  // Flush overrides any stall: fetch redirects, decode slot is killed.
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_bubble = 1'b0;
    if (flush) begin
      idex_bubble = 1'b1;
    end else if (stall) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  assign ex_load = id_valid && !idex_bubble;

  always_comb begin
    ex_d = '0;
    if (ex_load) begin
      ex_d.valid    = 1'b1;
      ex_d.rs       = id_rs;
      ex_d.rt       = id_rt;
      ex_d.rd       = id_rd;
      ex_d.regwrite = id_regwrite;
      ex_d.memread  = id_memread;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= ex_q;
      wb_q  <= mem_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_count <= '0;
    end else if (!pc_write && (stall_count != '1)) begin
      stall_count <= stall_count + 1'b1;
    end
  end

  fwd_sel_unit u_fwd_a (
    .src      (ex_q.rs),
    .mem_slot (mem_q),
    .wb_slot  (wb_q),
    .sel      (fwd_a_sel)
  );

  fwd_sel_unit u_fwd_b (
    .src      (ex_q.rt),
    .mem_slot (mem_q),
    .wb_slot  (wb_q),
    .sel      (fwd_b_sel)
  );

`ifdef HAZARD_MULDIV_EN
  state_t            state;
  logic [BUSY_W-1:0] busy_cnt;

  assign md_stall = (state == MD_BUSY) && id_valid && id_muldiv;

  // Counter reaches 0 on the same edge the FSM returns to RUN, so the unit
  // is busy for MULDIV_LAT-1 cycles after the mul/div enters EX.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= RUN;
      busy_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          if (ex_load && id_muldiv) begin
            state    <= MD_BUSY;
            busy_cnt <= BUSY_W'(MULDIV_LAT - 1);
          end
        end
        MD_BUSY: begin
          busy_cnt <= busy_cnt - 1'b1;
          if (busy_cnt == BUSY_W'(1)) begin
            state <= RUN;
          end
        end
        default: begin
          state    <= RUN;
          busy_cnt <= '0;
        end
      endcase
    end
  end
`else
  logic unused_md;
  assign md_stall  = 1'b0;
  assign unused_md = id_muldiv ^ (MULDIV_LAT == 0);
`endif

endmodule

// File: doc/hazard_fwd_unit.md
HAZARD_FWD_UNIT -- requirements
Module: hazard_fwd_unit

Interface
REQ-001 Parameters SHALL be: MULDIV_LAT, default 4, mul/div occupancy in cycles (2..15); CNT_W, default 16, width of the stall counter.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- id_valid  in  1  decode slot holds a real instruction.
- id_rs, id_rt  in  5  decode source registers.
- id_use_rs, id_use_rt  in  1  source actually read.
- id_rd  in  5  decode destination register.
- id_regwrite, id_memread  in  1  decode writes a register / is a load.
- id_muldiv  in  1  decode is a multi-cycle mul/div.
- flush  in  1  taken branch; kill the decode slot.
- fwd_a_sel, fwd_b_sel  out  2  EX operand select for the 3:1 operand mux.
- pc_write, ifid_write  out  1  PC and IF/ID enables.
- idex_bubble  out  1  zero the ID/EX control fields.
- stall_count  out  CNT_W  saturating count of stall cycles.

Function
REQ-003 The unit SHALL keep three internal slots, EX, MEM and WB. Each slot SHALL hold: valid, rs, rt, rd, regwrite, memread.
REQ-004 Each cycle MEM SHALL shift to WB and EX SHALL shift to MEM. The decode fields SHALL load into EX only if id_valid=1, idex_bubble=0 and flush=0; otherwise EX SHALL load invalid.
REQ-005 Forward select encoding SHALL be: 00 register-file value, 01 WB result, 10 MEM result. The value 11 SHALL never be driven.
REQ-006 fwd_a_sel SHALL be 10 if MEM.valid, MEM.regwrite, MEM.rd!=0 and MEM.rd==EX.rs. Otherwise it SHALL be 01 if the same conditions hold for WB. Otherwise it SHALL be 00. MEM SHALL take priority over WB. fwd_b_sel SHALL use the same rules on EX.rt.
REQ-007 fwd_a_sel and fwd_b_sel SHALL be combinational from the slot registers, with zero added latency.
REQ-008 Load-use SHALL be detected when all of the following hold:
- EX.valid, EX.memread and EX.regwrite are set, and EX.rd!=0;
- id_valid=1;
- EX.rd equals id_rs (with id_use_rs=1) or id_rt (with id_use_rt=1).
REQ-009 A load-use SHALL cause, in the same cycle: pc_write=0, ifid_write=0, idex_bubble=1. The stall SHALL last exactly one cycle, because the EX bubble removes the condition.
REQ-010 The FSM states SHALL be RUN and MD_BUSY.
- RUN to MD_BUSY: a valid id_muldiv instruction enters EX; the busy counter loads MULDIV_LAT-1.
- MD_BUSY: the counter decrements each cycle.
- MD_BUSY to RUN: when the counter reaches 0.
REQ-011 In MD_BUSY, an id_valid id_muldiv instruction SHALL stall, with the same outputs as REQ-009. Instructions that are not mul/div SHALL proceed.
REQ-012 When flush=1, flush SHALL win over every stall: pc_write=1, ifid_write=1, idex_bubble=1. The stall counter SHALL NOT increment. The FSM and busy counter SHALL continue unaffected.
REQ-013 stall_count SHALL increment on every cycle with pc_write=0. It SHALL saturate at all-ones.

Reset
REQ-014 While rst=0, all slots SHALL be invalid with zeroed fields, the FSM SHALL be in RUN, the busy counter SHALL be 0 and stall_count SHALL be 0.
REQ-015 Reset output values SHALL be: fwd_a_sel=00, fwd_b_sel=00, pc_write=1, ifid_write=1, idex_bubble=0.
REQ-016 Reset asserted mid-stall or in MD_BUSY SHALL abandon the operation immediately, asynchronously. Reset release SHALL resume in RUN.

Configuration
REQ-017 The macro HAZARD_MULDIV_EN SHALL control the mul/div logic. When defined, MD_BUSY, the busy counter and REQ-010/011 SHALL be present.
REQ-018 When HAZARD_MULDIV_EN is undefined, the id_muldiv port SHALL remain but be ignored. The FSM SHALL stay in RUN and no mul/div stall SHALL occur.

Structure
REQ-019 A shared package SHALL hold the forward select constants (FWD_RF=00, FWD_WB=01, FWD_MEM=10), the FSM state typedef and the slot struct typedef.
REQ-020 One sub-module, fwd_sel_unit, SHALL compute one 2-bit select from one source register and the MEM/WB slots. It SHALL be instantiated twice, for A and B.

Verification
REQ-021 The bench SHALL cover these scenarios:
- add r3 then sub r4,r3,r5 back-to-back -> fwd_a_sel=10 on the sub's EX cycle.
- add r3, nop, then and r6,r3,r3 -> fwd_a_sel=01 and fwd_b_sel=01.
- lw r2 then add r7,r2,r1 -> exactly one cycle of pc_write=0 and idex_bubble=1, then fwd_a_sel=01; stall_count=1.
- Writer to r0 followed by a reader of r0 -> selects stay 00 and no stall.
- With HAZARD_MULDIV_EN and MULDIV_LAT=4: mult, then mult next cycle -> the second mult stalls 3 cycles; a non-muldiv add is never stalled.
- Load-use with flush=1 in the same cycle -> pc_write=1 and idex_bubble=1. rst=0 asserted mid-MD_BUSY -> all outputs at reset values before the next clock edge.
